// File: rtl/mdu_if.sv
// Request/response bundle between an issuing pipeline and the multiply/divide unit.
interface mdu_if #(
    parameter int WIDTH = 32
);
    // start is a request strobe taken only while busy=0 and no done pulse is showing;
    // the issuer holds its request (stalls) while busy=1, and done marks completion for one cycle.
    logic             start;
    logic [5:0]       f_bits;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] result;
    logic             divz;
    logic             illegal;

    modport master (
        output start, f_bits, a, b,
        input  busy, done, hi, lo, result, divz, illegal
    );

    modport slave (
        input  start, f_bits, a, b,
        output busy, done, hi, lo, result, divz, illegal
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative MIPS-style HI/LO unit: shift-add multiply, restoring divide,
// plus single-cycle mthi/mtlo/mfhi/mflo.
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mdu_if.slave       bus,
    output logic [1:0] state_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             op_div_q, neg_q, rneg_q, divz_pend_q;
    logic [WIDTH-1:0] m_q, q_q, acc_q;
    logic [WIDTH-1:0] hi_q, lo_q, result_q;
    logic             done_q, divz_q, illegal_q;

    logic             is_md, is_div, signed_op, sa, sb;
    logic             is_mfhi, is_mthi, is_mflo, is_mtlo;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        is_md     = (bus.f_bits[5:2] == 4'b0110);
        is_div    = bus.f_bits[1];
        signed_op = ~bus.f_bits[0];
        is_mfhi   = (bus.f_bits == 6'b010000);
        is_mthi   = (bus.f_bits == 6'b010001);
        is_mflo   = (bus.f_bits == 6'b010010);
        is_mtlo   = (bus.f_bits == 6'b010011);
        sa        = signed_op & bus.a[WIDTH-1];
        sb        = signed_op & bus.b[WIDTH-1];
        // Magnitude of the most-negative value still fits as an unsigned WIDTH-bit number.
        a_mag     = sa ? -bus.a : bus.a;
        b_mag     = sb ? -bus.b : bus.b;
    end

    // Multiply keeps the multiplicand in m_q and the multiplier in q_q; divide keeps
    // the divisor in m_q and shifts the dividend out of q_q while quotient bits shift in.
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, hi_fin, lo_fin;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, q_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, m_q});
        div_diff  = div_shift[WIDTH-1:0] - m_q;
        prod      = {acc_q, q_q};
        prod_fix  = neg_q ? -prod : prod;
        quo_fix   = divz_pend_q ? {WIDTH{1'b1}} : (neg_q ? -q_q : q_q);
        rem_fix   = rneg_q ? -acc_q : acc_q;
        hi_fin    = op_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_fin    = op_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            divz_pend_q <= 1'b0;
            m_q         <= '0;
            q_q         <= '0;
            acc_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            divz_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            divz_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Refusing a start during a done pulse keeps done from firing twice in a row.
                    if (bus.start && !done_q) begin
                        if (is_md) begin
                            state_q     <= RUN;
                            cnt_q       <= '0;
                            op_div_q    <= is_div;
                            neg_q       <= sa ^ sb;
                            rneg_q      <= sa;
                            divz_pend_q <= is_div && (bus.b == '0);
                            m_q         <= is_div ? b_mag : a_mag;
                            q_q         <= is_div ? a_mag : b_mag;
                            acc_q       <= '0;
                        end else begin
                            done_q    <= 1'b1;
                            illegal_q <= ~(is_mfhi | is_mthi | is_mflo | is_mtlo);
                            if (is_mthi) hi_q <= bus.a;
                            if (is_mtlo) lo_q <= bus.a;
                            if (is_mfhi) result_q <= hi_q;
                            if (is_mflo) result_q <= lo_q;
                        end
                    end
                end
                RUN: begin
                    if (op_div_q) begin
                        acc_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        q_q   <= {q_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_q <= mul_sum[WIDTH:1];
                        q_q   <= {mul_sum[0], q_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        divz_q  <= divz_pend_q;
                    end
                end
                FIN: begin
                    hi_q    <= hi_fin;
                    lo_q    <= lo_fin;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.result  = result_q;
    assign bus.divz    = divz_q;
    assign bus.illegal = illegal_q;
    assign state_o     = state_q;
endmodule
